// File: rtl/commit_aligner.sv
// commit_aligner: aligns DUT and reference commit streams through per-side FIFOs and compares them pairwise.
// Optional watchdog enabled by defining COMMIT_ALIGNER_TIMEOUT_EN.
module commit_aligner #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dut_valid,
    input  logic [63:0] dut_pc,
    input  logic [4:0]  dut_rd_addr,
    input  logic [63:0] dut_rd_wdata,
    input  logic        ref_valid,
    input  logic [63:0] ref_pc,
    input  logic [4:0]  ref_rd_addr,
    input  logic [63:0] ref_rd_wdata,
    output logic        mismatch,
    output logic [1:0]  mismatch_field,
    output logic [63:0] mismatch_pc,
    output logic        overflow,
    output logic        timeout,
    output logic [31:0] compared_count,
    output logic [1:0]  state
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE = 2'b00, PENDING = 2'b01, FAIL = 2'b10} state_t;
    state_t state_q, state_n;
    logic [132:0] d_mem [DEPTH];
    logic [132:0] r_mem [DEPTH];
    logic [AW:0] d_wp, d_rp, r_wp, r_rp, d_wp_n, d_rp_n, r_wp_n, r_rp_n;
    logic d_empty, r_empty, d_full, r_full, pop, d_push, r_push, drop, timeout_n;
    logic [132:0] d_head, r_head;
    logic [1:0] field;

    assign d_empty = d_wp == d_rp;
    assign r_empty = r_wp == r_rp;
    assign d_full  = (d_wp ^ d_rp) == {1'b1, {AW{1'b0}}};
    assign r_full  = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
    assign pop     = !d_empty && !r_empty;
    assign d_push  = dut_valid && (!d_full || pop);
    assign r_push  = ref_valid && (!r_full || pop);
    assign drop    = (dut_valid && d_full && !pop) || (ref_valid && r_full && !pop);
    assign d_head  = d_mem[d_rp[AW-1:0]];
    assign r_head  = r_mem[r_rp[AW-1:0]];
    assign field   = (d_head[132:69] != r_head[132:69]) ? 2'b01 :
                     (d_head[68:64] != r_head[68:64]) ? 2'b10 :
                     (d_head[68:64] != 5'd0 && d_head[63:0] != r_head[63:0]) ? 2'b11 : 2'b00;
    assign state   = state_q;

    // next pointer values, shared by the registers and the next-state logic
    always_comb begin
        d_wp_n = d_wp + {{AW{1'b0}}, d_push};
        r_wp_n = r_wp + {{AW{1'b0}}, r_push};
        d_rp_n = d_rp + {{AW{1'b0}}, pop};
        r_rp_n = r_rp + {{AW{1'b0}}, pop};
    end

    // FIFO storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge clock) begin
        if (d_push) d_mem[d_wp[AW-1:0]] <= {dut_pc, dut_rd_addr, dut_rd_wdata};
        if (r_push) r_mem[r_wp[AW-1:0]] <= {ref_pc, ref_rd_addr, ref_rd_wdata};
    end

    // pointers, compare results and sticky flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_wp           <= '0;
            d_rp           <= '0;
            r_wp           <= '0;
            r_rp           <= '0;
            mismatch       <= 1'b0;
            mismatch_field <= 2'b00;
            mismatch_pc    <= '0;
            overflow       <= 1'b0;
            compared_count <= '0;
        end else begin
            d_wp <= d_wp_n;
            d_rp <= d_rp_n;
            r_wp <= r_wp_n;
            r_rp <= r_rp_n;
            if (pop && compared_count != '1) compared_count <= compared_count + 32'd1;
            if (pop && field != 2'b00 && !mismatch) begin
                mismatch       <= 1'b1;
                mismatch_field <= field;
                mismatch_pc    <= d_head[132:69];
            end
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef COMMIT_ALIGNER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd, wd_n;
    assign wd_n      = (pop || (d_empty && r_empty)) ? '0 : (wd == WW'(TIMEOUT)) ? wd : wd + WW'(1);
    assign timeout_n = timeout || (wd_n == WW'(TIMEOUT));

    // watchdog counts cycles where exactly one side holds entries
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else begin
            wd      <= wd_n;
            timeout <= timeout_n;
        end
    end
`else
    assign timeout   = TIMEOUT < 0;
    assign timeout_n = 1'b0;
`endif

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // next state follows the post-edge flags and occupancy; FAIL is absorbing
    always_comb begin
        state_n = state_q;
        if (state_q == FAIL || mismatch || overflow || timeout_n || drop || (pop && field != 2'b00))
            state_n = FAIL;
        else
            state_n = (d_wp_n == d_rp_n && r_wp_n == r_rp_n) ? IDLE : PENDING;
    end
endmodule

// File: doc/commit_aligner.md
COMMIT_ALIGNER -- requirements
Module: commit_aligner

Interface
REQ-001 Parameter DEPTH, default 4, entries per side FIFO; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 16, watchdog limit in cycles; used only under REQ-030.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 dut_valid  input  1  DUT retired one instruction this cycle.
REQ-006 dut_pc / dut_rd_addr / dut_rd_wdata  input  64/5/64  DUT commit PC, destination register, written value.
REQ-007 ref_valid  input  1  reference model retired one instruction this cycle.
REQ-008 ref_pc / ref_rd_addr / ref_rd_wdata  input  64/5/64  reference commit PC, destination register, written value.
REQ-009 mismatch  output  1  sticky; a compared commit pair differed.
REQ-010 mismatch_field  output  2  first failing field: 00 none, 01 pc, 10 rd, 11 wdata.
REQ-011 mismatch_pc  output  64  DUT PC of the first mismatching pair.
REQ-012 overflow  output  1  sticky; a commit was dropped on a full FIFO.
REQ-013 timeout  output  1  sticky; one side ran ahead too long.
REQ-014 compared_count  output  32  number of commit pairs compared.
REQ-015 state  output  2  00 IDLE, 01 PENDING, 10 FAIL.

Function
REQ-016 Each side SHALL own a DEPTH-entry FIFO of {pc, rd, wdata}; a valid input pushes at the clock edge.
REQ-017 A push on a full FIFO SHALL be accepted only if that FIFO pops in the same cycle; otherwise the entry is dropped and overflow sets.
REQ-018 When both FIFOs are non-empty, both heads SHALL be popped and compared in the same cycle; an entry pushed at edge N is comparable no earlier than the cycle after N.
REQ-019 Latency: both valid on empty FIFOs before edge N gives compared_count and mismatch updated at edge N+1.
REQ-020 Compare priority SHALL be pc, then rd, then wdata; when both rd equal 0, wdata SHALL be ignored.
REQ-021 The first mismatch SHALL latch mismatch_field and mismatch_pc; later mismatches SHALL NOT alter them.
REQ-022 compared_count SHALL increment per compared pair and saturate at 0xFFFFFFFF.
REQ-023 FSM: IDLE when both FIFOs are empty; PENDING when exactly one is non-empty or a compare is pending.
REQ-024 FSM: FAIL when mismatch, overflow or timeout is set; FAIL is absorbing until reset.
REQ-025 In FAIL, FIFOs and compare SHALL keep operating; only state is frozen.
REQ-026 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-027 Reset SHALL clear both FIFOs, all sticky flags, mismatch_field, mismatch_pc, compared_count and the watchdog, and set state to IDLE.
REQ-028 Reset asserted mid-operation SHALL discard in-flight entries immediately, without waiting for a clock edge.
REQ-029 Inputs SHALL be ignored while reset is high.

Configuration
REQ-030 Macro COMMIT_ALIGNER_TIMEOUT_EN defined: a watchdog SHALL count cycles in which exactly one FIFO is non-empty.
REQ-031 The watchdog SHALL clear on any compare or when both FIFOs are empty, and SHALL set timeout on reaching TIMEOUT.
REQ-032 Macro undefined: timeout SHALL be tied to 0, the watchdog SHALL be absent and TIMEOUT unused.

Verification
REQ-033 Lockstep: 10 identical commits (pc 0x80000000+4i) on both sides -> compared_count=10, mismatch=0, state IDLE at end.
REQ-034 Skew: DUT commits 3 entries, ref commits the same 3 entries 2 cycles later -> compared_count=3, no mismatch, no overflow.
REQ-035 wdata differs at commit 2, rd=5 -> mismatch=1, field=11, mismatch_pc=0x80000008, state FAIL.
REQ-036 rd=0 with differing wdata -> no mismatch; a following pc difference -> field=01.
REQ-037 DUT pushes 5 entries with ref silent, DEPTH=4 -> overflow=1, FAIL; reset mid-stream -> all outputs 0, IDLE.
REQ-038 With COMMIT_ALIGNER_TIMEOUT_EN and TIMEOUT=16, one DUT commit then ref silent -> timeout=1 exactly 16 cycles after the push edge; without the macro, timeout stays 0.
